// File: rtl/sprite_draw_arbiter_pkg.sv
// Shared types and constants for the sprite draw arbiter: FSM encoding,
// default screen/sprite geometry, colour constants and the coordinate clamp.
package sprite_draw_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ERASE = 2'd1,
        DRAW  = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam int SPRITE_W_DEF = 5;
    localparam int SCREEN_W_DEF = 320;
    localparam int SCREEN_H_DEF = 240;

    localparam logic [2:0] BLACK = 3'b000;
    localparam logic [2:0] BLUE  = 3'b001;
    localparam logic [2:0] RED   = 3'b100;

    function automatic logic [9:0] clamp_coord(input logic [9:0] v, input logic [9:0] lim);
        return (v > lim) ? lim : v;
    endfunction

endpackage

// File: rtl/rr_arbiter_2.sv
// Two-way round-robin arbiter: one-hot grant, pointer flips to the other
// requester whenever a grant is taken.
module rr_arbiter_2 (
    input  logic       clock,
    input  logic       reset,
    input  logic [1:0] req,
    input  logic       advance,
    output logic [1:0] grant
);

    // ptr_q is the requester that wins a tie
    logic ptr_q, ptr_d;

    always_comb begin
        grant = req;
        if (req == 2'b11) begin
            grant = ptr_q ? 2'b10 : 2'b01;
        end
        ptr_d = ptr_q;
        if (advance && (req != 2'b00)) begin
            ptr_d = grant[0];
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            ptr_q <= 1'b0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/sprite_draw_arbiter.sv
// Arbitrates two sprite-move requesters onto one draw engine: erase the old
// sprite position (if any), then draw the new one, then acknowledge.
module sprite_draw_arbiter
    import sprite_draw_arbiter_pkg::*;
#(
    parameter int         SPRITE_W  = SPRITE_W_DEF,
    parameter int         SCREEN_W  = SCREEN_W_DEF,
    parameter int         SCREEN_H  = SCREEN_H_DEF,
    parameter logic [2:0] BG_COLOUR = BLACK
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [1:0] req,
    input  logic [9:0] req_x0,
    input  logic [9:0] req_x1,
    input  logic [8:0] req_y0,
    input  logic [8:0] req_y1,
    input  logic [2:0] req_colour0,
    input  logic [2:0] req_colour1,
    output logic [1:0] ack,
    output logic       busy,
    output logic       eng_enable,
    output logic [9:0] eng_x,
    output logic [8:0] eng_y,
    input  logic       eng_finished,
    output logic       plot,
    output logic [2:0] colour
);

    localparam logic [9:0] MAX_X = 10'(SCREEN_W - SPRITE_W);
    localparam logic [9:0] MAX_Y = 10'(SCREEN_H - SPRITE_W);

    state_t          state_q, state_d;
    logic [1:0]      gnt_q, gnt_d;
    logic [9:0]      lat_x_q, lat_x_d;
    logic [8:0]      lat_y_q, lat_y_d;
    logic [2:0]      lat_col_q, lat_col_d;
    logic [1:0][9:0] prev_x_q, prev_x_d;
    logic [1:0][8:0] prev_y_q, prev_y_d;
    logic [1:0]      prev_valid_q, prev_valid_d;
    logic [1:0]      ack_q, ack_d;
    logic            busy_q, busy_d;
    logic            eng_enable_q, eng_enable_d;
    logic [9:0]      eng_x_q, eng_x_d;
    logic [8:0]      eng_y_q, eng_y_d;
    logic            plot_q, plot_d;
    logic [2:0]      colour_q, colour_d;

    logic [1:0] grant;
    logic       sel;
    logic [9:0] sel_x_cl;
    logic [8:0] sel_y_cl;
    logic [2:0] sel_col;
    logic       gidx;

    rr_arbiter_2 u_rr (
        .clock   (clock),
        .reset   (reset),
        .req     (req),
        .advance (state_q == IDLE),
        .grant   (grant)
    );

    assign sel      = grant[1];
    assign gidx     = gnt_q[1];
    assign sel_x_cl = clamp_coord(sel ? req_x1 : req_x0, MAX_X);
    assign sel_y_cl = 9'(clamp_coord({1'b0, sel ? req_y1 : req_y0}, MAX_Y));
    assign sel_col  = sel ? req_colour1 : req_colour0;

    always_comb begin
        state_d      = state_q;
        gnt_d        = gnt_q;
        lat_x_d      = lat_x_q;
        lat_y_d      = lat_y_q;
        lat_col_d    = lat_col_q;
        prev_x_d     = prev_x_q;
        prev_y_d     = prev_y_q;
        prev_valid_d = prev_valid_q;
        ack_d        = 2'b00;
        busy_d       = busy_q;
        eng_enable_d = eng_enable_q;
        eng_x_d      = eng_x_q;
        eng_y_d      = eng_y_q;
        plot_d       = plot_q;
        colour_d     = colour_q;
        case (state_q)
            IDLE: begin
                if (req != 2'b00) begin
                    gnt_d        = grant;
                    lat_x_d      = sel_x_cl;
                    lat_y_d      = sel_y_cl;
                    lat_col_d    = sel_col;
                    busy_d       = 1'b1;
                    eng_enable_d = 1'b1;
                    plot_d       = 1'b1;
                    if (prev_valid_q[sel]) begin
                        state_d  = ERASE;
                        eng_x_d  = prev_x_q[sel];
                        eng_y_d  = prev_y_q[sel];
                        colour_d = BG_COLOUR;
                    end else begin
                        state_d  = DRAW;
                        eng_x_d  = sel_x_cl;
                        eng_y_d  = sel_y_cl;
                        colour_d = sel_col;
                    end
                end
            end
            ERASE: begin
                // Drop enable for one cycle so the engine sees a fresh start
                if (eng_finished) begin
                    state_d      = DRAW;
                    eng_enable_d = 1'b0;
                    plot_d       = 1'b0;
                    eng_x_d      = lat_x_q;
                    eng_y_d      = lat_y_q;
                    colour_d     = lat_col_q;
                end
            end
            DRAW: begin
                if (!eng_enable_q) begin
                    eng_enable_d = 1'b1;
                    plot_d       = 1'b1;
                end else if (eng_finished) begin
                    state_d      = DONE;
                    eng_enable_d = 1'b0;
                    plot_d       = 1'b0;
                    ack_d        = gnt_q;
                end
            end
            DONE: begin
                state_d            = IDLE;
                prev_x_d[gidx]     = lat_x_q;
                prev_y_d[gidx]     = lat_y_q;
                prev_valid_d[gidx] = 1'b1;
                busy_d             = 1'b0;
                eng_x_d            = 10'd0;
                eng_y_d            = 9'd0;
                colour_d           = 3'b000;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= IDLE;
            gnt_q        <= 2'b00;
            lat_x_q      <= '0;
            lat_y_q      <= '0;
            lat_col_q    <= '0;
            prev_x_q     <= '0;
            prev_y_q     <= '0;
            prev_valid_q <= 2'b00;
            ack_q        <= 2'b00;
            busy_q       <= 1'b0;
            eng_enable_q <= 1'b0;
            eng_x_q      <= '0;
            eng_y_q      <= '0;
            plot_q       <= 1'b0;
            colour_q     <= '0;
        end else begin
            state_q      <= state_d;
            gnt_q        <= gnt_d;
            lat_x_q      <= lat_x_d;
            lat_y_q      <= lat_y_d;
            lat_col_q    <= lat_col_d;
            prev_x_q     <= prev_x_d;
            prev_y_q     <= prev_y_d;
            prev_valid_q <= prev_valid_d;
            ack_q        <= ack_d;
            busy_q       <= busy_d;
            eng_enable_q <= eng_enable_d;
            eng_x_q      <= eng_x_d;
            eng_y_q      <= eng_y_d;
            plot_q       <= plot_d;
            colour_q     <= colour_d;
        end
    end

    assign ack        = ack_q;
    assign busy       = busy_q;
    assign eng_enable = eng_enable_q;
    assign eng_x      = eng_x_q;
    assign eng_y      = eng_y_q;
    assign plot       = plot_q;
    assign colour     = colour_q;

endmodule

// File: tb/tb_sprite_draw_arbiter.sv
// Scoreboard bench for sprite_draw_arbiter: stimulus queues expected passes
// and acks, a negedge monitor pops and compares them as the DUT presents them.
module tb_sprite_draw_arbiter;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic [1:0] req = 2'b00;
    logic [9:0] req_x0 = '0, req_x1 = '0;
    logic [8:0] req_y0 = '0, req_y1 = '0;
    logic [2:0] req_colour0 = '0, req_colour1 = '0;
    logic [1:0] ack;
    logic       busy, eng_enable, plot;
    logic [9:0] eng_x;
    logic [8:0] eng_y;
    logic [2:0] colour;
    logic       fin_eng = 1'b0, fin_extra = 1'b0;
    logic       eng_finished;

    assign eng_finished = fin_eng | fin_extra;

    sprite_draw_arbiter dut (
        .clock        (clock),
        .reset        (reset),
        .req          (req),
        .req_x0       (req_x0),
        .req_x1       (req_x1),
        .req_y0       (req_y0),
        .req_y1       (req_y1),
        .req_colour0  (req_colour0),
        .req_colour1  (req_colour1),
        .ack          (ack),
        .busy         (busy),
        .eng_enable   (eng_enable),
        .eng_x        (eng_x),
        .eng_y        (eng_y),
        .eng_finished (eng_finished),
        .plot         (plot),
        .colour       (colour)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic [9:0] x;
        logic [8:0] y;
        logic [2:0] c;
    } pass_t;

    pass_t      pass_q[$];
    logic [1:0] ack_q[$];
    int         checks = 0;
    int         fails = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic push_pass(input int x, input int y, input int c);
        pass_t p;
        p.x = 10'(x);
        p.y = 9'(y);
        p.c = 3'(c);
        pass_q.push_back(p);
    endtask

    // Draw-engine model: finishes a pass after three enabled cycles
    initial begin
        int cnt;
        cnt = 0;
        forever begin
            tick();
            if (eng_enable && !reset) begin
                cnt++;
                if (cnt == 3) begin
                    fin_eng = 1'b1;
                    cnt = 0;
                end else begin
                    fin_eng = 1'b0;
                end
            end else begin
                cnt = 0;
                fin_eng = 1'b0;
            end
        end
    end

    // Monitor
    logic  en_prev = 1'b0;
    logic  fin_prev = 1'b0;
    int    low_cnt = 0;
    pass_t exp_pass;
    logic [1:0] exp_ack;

    always @(negedge clock) begin
        if (reset) begin
            en_prev  = 1'b0;
            fin_prev = 1'b0;
            low_cnt  = 0;
        end else begin
            check("plot_tracks_enable", plot, eng_enable);
            if (!busy) begin
                check("idle_outputs_zero", {ack, eng_enable, plot, eng_x, eng_y, colour}, 0);
                low_cnt = 0;
            end else if (!eng_enable) begin
                low_cnt++;
            end
            if (eng_enable && !en_prev) begin
                if (low_cnt != 0) check("enable_gap_len", low_cnt, 1);
                low_cnt = 0;
                if (pass_q.size() == 0) begin
                    checks++;
                    fails++;
                    $display("FAIL unexpected_pass: got x=%0d y=%0d colour=%0d, expected none", eng_x, eng_y, colour);
                end else begin
                    exp_pass = pass_q.pop_front();
                    check("pass_x", eng_x, exp_pass.x);
                    check("pass_y", eng_y, exp_pass.y);
                    check("pass_colour", colour, exp_pass.c);
                end
            end
            if (ack != 2'b00) begin
                check("ack_after_finished", fin_prev, 1);
                if (ack_q.size() == 0) begin
                    checks++;
                    fails++;
                    $display("FAIL unexpected_ack: got %0d, expected none", ack);
                end else begin
                    exp_ack = ack_q.pop_front();
                    check("ack_value", ack, exp_ack);
                end
            end
            en_prev  = eng_enable;
            fin_prev = eng_finished;
        end
    end

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while (busy && n < 200) begin
            tick();
            n++;
        end
        check({name, "_idle_timeout"}, busy, 0);
    endtask

    task automatic set_req(input int i, input int x, input int y, input int c);
        if (i == 0) begin
            req_x0 = 10'(x); req_y0 = 9'(y); req_colour0 = 3'(c);
        end else begin
            req_x1 = 10'(x); req_y1 = 9'(y); req_colour1 = 3'(c);
        end
    endtask

    // One move: optional erase of (px,py), then draw at (ex,ey,ec), then ack
    task automatic move(input string name, input int i, input int x, input int y, input int c,
                        input int ex, input int ey, input int ec,
                        input bit erase, input int px, input int py);
        if (erase) push_pass(px, py, 0);
        push_pass(ex, ey, ec);
        ack_q.push_back(i == 1 ? 2'b10 : 2'b01);
        set_req(i, x, y, c);
        req = (i == 1) ? 2'b10 : 2'b01;
        tick();
        check({name, "_enable_after_grant"}, eng_enable, 1);
        check({name, "_busy_after_grant"}, busy, 1);
        req = 2'b00;
        wait_idle(name);
        tick();
    endtask

    initial begin
        int n;
        int acks;
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        check("rst_ack", ack, 0);
        check("rst_busy", busy, 0);
        check("rst_enable", eng_enable, 0);
        check("rst_plot", plot, 0);
        check("rst_colour", colour, 0);

        // First move: no previous position, so draw only
        move("first", 0, 240, 100, 1, 240, 100, 1, 1'b0, 0, 0);
        // Second move: erase old spot in background colour, then draw
        move("second", 0, 100, 100, 1, 100, 100, 1, 1'b1, 240, 100);

        // Finished pulse while idle must be ignored
        fin_extra = 1'b1;
        tick();
        fin_extra = 1'b0;
        check("idle_fin_busy", busy, 0);
        tick();
        check("idle_fin_busy2", busy, 0);
        check("idle_fin_ack", ack, 0);
        check("idle_fin_enable", eng_enable, 0);

        // Clamping at right/bottom screen edges
        move("clamp", 0, 330, 250, 4, 315, 235, 4, 1'b1, 100, 100);

        // Reset in the middle of a draw pass
        push_pass(5, 5, 4);
        set_req(1, 5, 5, 4);
        req = 2'b10;
        tick();
        check("middraw_enable", eng_enable, 1);
        req = 2'b00;
        tick();
        reset = 1'b1;
        tick();
        check("middraw_rst_enable", eng_enable, 0);
        check("middraw_rst_plot", plot, 0);
        check("middraw_rst_busy", busy, 0);
        reset = 1'b0;
        tick();
        move("post_reset", 0, 10, 10, 1, 10, 10, 1, 1'b0, 0, 0);

        // Both requesting continuously: grants alternate from requester 0
        reset = 1'b1;
        tick();
        reset = 1'b0;
        tick();
        push_pass(20, 30, 1);
        ack_q.push_back(2'b01);
        push_pass(50, 60, 4);
        ack_q.push_back(2'b10);
        push_pass(20, 30, 0);
        push_pass(20, 30, 1);
        ack_q.push_back(2'b01);
        push_pass(50, 60, 0);
        push_pass(50, 60, 4);
        ack_q.push_back(2'b10);
        set_req(0, 20, 30, 1);
        set_req(1, 50, 60, 4);
        req = 2'b11;
        n = 0;
        acks = 0;
        while (acks < 4 && n < 400) begin
            tick();
            n++;
            if (ack != 2'b00) acks++;
        end
        req = 2'b00;
        check("alt_ack_count", acks, 4);
        wait_idle("alt");
        tick();

        check("pass_queue_drained", pass_q.size(), 0);
        check("ack_queue_drained", ack_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no end of test, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
